// File: rtl/m707_tty_tx.sv
// m707_tty_tx: teletype transmitter, sends a character as an async start/data/stop frame
//   clk, rst          master clock, synchronous active-high reset
//   load_n, d         falling edge of load_n latches d and starts a frame
//   clr_flag_n        falling edge clears the transmit-done flag
//   line              serial loop output (1 = mark/idle, 0 = space)
//   flag, flag_n      transmit-done flag and its complement
//   active            high while a frame is in progress
//   M707_PARITY_EN    when defined, an even-parity bit follows d[7]
module m707_tty_tx #(
  parameter int BIT_CLKS  = 16,
  parameter int STOP_BITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_n,
  input  logic       clr_flag_n,
  input  logic [7:0] d,
  output logic       line,
  output logic       flag,
  output logic       flag_n,
  output logic       active
);
  localparam int DW = $clog2(STOP_BITS * BIT_CLKS);
  localparam logic [DW-1:0] BIT_END  = DW'(BIT_CLKS - 1);
  localparam logic [DW-1:0] STOP_END = DW'(STOP_BITS * BIT_CLKS - 1);
`ifdef M707_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t          r_state;
  logic            r_prev_load;
  logic            r_prev_clr;
  logic            r_line;
  logic            r_flag;
  logic            r_active;
  logic [2:0]      r_bit;
  logic [DW-1:0]   r_div;
  logic [7:0]      r_sr;
  logic            w_load_edge;
  logic            w_clr_edge;
  logic            w_bit_end;
  logic [2:0]      w_next_bit;
  assign w_load_edge = r_prev_load & ~load_n;
  assign w_clr_edge  = r_prev_clr & ~clr_flag_n;
  assign w_bit_end   = r_div == BIT_END;
  assign w_next_bit  = r_bit + 3'd1;
  assign line   = r_line;
  assign flag   = r_flag;
  assign flag_n = ~r_flag;
  assign active = r_active;
  // Clear is applied first so that a flag set in the same cycle overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_prev_load <= 1'b1;
      r_prev_clr  <= 1'b1;
      r_line      <= 1'b1;
      r_flag      <= 1'b0;
      r_active    <= 1'b0;
      r_bit       <= '0;
      r_div       <= '0;
      r_sr        <= '0;
    end else begin
      r_prev_load <= load_n;
      r_prev_clr  <= clr_flag_n;
      if (w_clr_edge) r_flag <= 1'b0;
      case (r_state)
        IDLE: if (w_load_edge) begin
          r_sr     <= d;
          r_flag   <= 1'b0;
          r_state  <= START;
          r_line   <= 1'b0;
          r_active <= 1'b1;
          r_div    <= '0;
          r_bit    <= '0;
        end
        START: if (w_bit_end) begin
          r_state <= DATA;
          r_line  <= r_sr[0];
          r_div   <= '0;
        end else r_div <= r_div + DW'(1);
        DATA: if (w_bit_end) begin
          r_div <= '0;
          if (r_bit == 3'd7) begin
`ifdef M707_PARITY_EN
            r_state <= PARITY;
            r_line  <= ^r_sr;
`else
            r_state <= STOP;
            r_line  <= 1'b1;
`endif
          end else begin
            r_bit  <= w_next_bit;
            r_line <= r_sr[w_next_bit];
          end
        end else r_div <= r_div + DW'(1);
`ifdef M707_PARITY_EN
        PARITY: if (w_bit_end) begin
          r_state <= STOP;
          r_line  <= 1'b1;
          r_div   <= '0;
        end else r_div <= r_div + DW'(1);
`endif
        STOP: if (r_div == STOP_END) begin
          r_state  <= IDLE;
          r_active <= 1'b0;
          r_flag   <= 1'b1;
          r_div    <= '0;
        end else r_div <= r_div + DW'(1);
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_m707_tty_tx.sv
// tb_m707_tty_tx: randomized and directed bench for m707_tty_tx against a frame-level model
module tb_m707_tty_tx;
`ifdef M707_PARITY_EN
  localparam int PB = 1;
  localparam int FL0_LIT = 192;
  localparam int FL1_LIT = 44;
`else
  localparam int PB = 0;
  localparam int FL0_LIT = 176;
  localparam int FL1_LIT = 40;
`endif
  function automatic int bc(input int i);
    return i == 0 ? 16 : 4;
  endfunction
  function automatic int fl(input int i);
    return (9 + PB + (i == 0 ? 2 : 1)) * bc(i);
  endfunction
  logic       clk = 1'b0;
  logic       rst [2];
  logic       load_n [2];
  logic       clr_n [2];
  logic [7:0] d [2];
  logic       line [2];
  logic       flag [2];
  logic       flag_n [2];
  logic       active [2];
  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  m707_tty_tx #(.BIT_CLKS(16), .STOP_BITS(2)) dut0 (
    .clk(clk), .rst(rst[0]), .load_n(load_n[0]), .clr_flag_n(clr_n[0]), .d(d[0]),
    .line(line[0]), .flag(flag[0]), .flag_n(flag_n[0]), .active(active[0])
  );
  m707_tty_tx #(.BIT_CLKS(4), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst[1]), .load_n(load_n[1]), .clr_flag_n(clr_n[1]), .d(d[1]),
    .line(line[1]), .flag(flag[1]), .flag_n(flag_n[1]), .active(active[1])
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 50) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: a frame is a bit vector, position in the frame is a plain cycle count.
  bit        m_busy [2] = '{0, 0};
  bit        m_flag [2] = '{0, 0};
  bit        m_pl [2] = '{1, 1};
  bit        m_pc [2] = '{1, 1};
  int        m_n [2] = '{0, 0};
  logic [11:0] m_fr [2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        m_busy[i] = 0;
        m_flag[i] = 0;
        m_pl[i] = 1;
        m_pc[i] = 1;
      end else begin
        bit le, ce, set, acc;
        le = m_pl[i] && !load_n[i];
        ce = m_pc[i] && !clr_n[i];
        set = 0;
        acc = 0;
        if (m_busy[i]) begin
          m_n[i]++;
          if (m_n[i] == fl(i)) begin
            m_busy[i] = 0;
            set = 1;
          end
        end else if (le) begin
          m_busy[i] = 1;
          m_n[i] = 0;
          m_fr[i] = '1;
          m_fr[i][0] = 1'b0;
          m_fr[i][8:1] = d[i];
          if (PB == 1) m_fr[i][9] = ^d[i];
          acc = 1;
        end
        if (set) m_flag[i] = 1;
        else if (ce || acc) m_flag[i] = 0;
        m_pl[i] = load_n[i];
        m_pc[i] = clr_n[i];
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int el;
        el = m_busy[i] ? int'(m_fr[i][m_n[i] / bc(i)]) : 1;
        chk($sformatf("line%0d", i), int'(line[i]), el);
        chk($sformatf("active%0d", i), int'(active[i]), int'(m_busy[i]));
        chk($sformatf("flag%0d", i), int'(flag[i]), int'(m_flag[i]));
        chk($sformatf("flag_n%0d", i), int'(flag_n[i]), int'(!m_flag[i]));
      end
    end
  end
  // Samples each bit cell mid-way after the line falls; ftf = cycles from fall to flag.
  task automatic measure(input int i, output logic [9:0] s, output int ftf);
    int n;
    int w;
    s = '0;
    ftf = -1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (line[i] !== 1'b0 && w < 50);
    if (line[i] !== 1'b0) begin
      chk($sformatf("line_fall_timeout%0d", i), int'(line[i]), 0);
      return;
    end
    n = 0;
    while (flag[i] !== 1'b1 && n < 1000) begin
      for (int k = 0; k < 10; k++) if (n == bc(i) * k + bc(i) / 2) s[k] = line[i];
      @(negedge clk);
      n++;
    end
    ftf = n;
  endtask
  task automatic send(input int i, input logic [7:0] v, output logic [9:0] s, output int ftf);
    d[i] = v;
    load_n[i] = 1'b0;
    fork
      measure(i, s, ftf);
      begin
        @(negedge clk);
        load_n[i] = 1'b1;
      end
    join
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [9:0] s;
    int ftf;
    int cnt;
    rst = '{1'b1, 1'b1};
    load_n = '{1'b1, 1'b1};
    clr_n = '{1'b1, 1'b1};
    d = '{8'h00, 8'h00};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = '{1'b0, 1'b0};
    chk_en = 1'b1;
    chk("rst_line", int'(line[0]), 1);
    chk("rst_flag", int'(flag[0]), 0);
    chk("rst_flag_n", int'(flag_n[0]), 1);
    chk("rst_active", int'(active[0]), 0);
    send(0, 8'h55, s, ftf);
    chk("t1_fall_to_flag", ftf, FL0_LIT);
    chk("t1_start", int'(s[0]), 0);
    chk("t1_data", int'(s[8:1]), 8'h55);
    chk("t1_after_d7", int'(s[9]), PB == 1 ? 0 : 1);
    d[0] = 8'hFF;
    load_n[0] = 1'b0;
    fork
      measure(0, s, ftf);
      begin
        repeat (40) @(negedge clk);
        load_n[0] = 1'b1;
        d[0] = 8'($urandom);
        repeat (59) @(negedge clk);
        d[0] = 8'h00;
        load_n[0] = 1'b0;
        @(negedge clk);
        load_n[0] = 1'b1;
      end
    join
    chk("t2_fall_to_flag", ftf, FL0_LIT);
    chk("t2_data", int'(s[8:1]), 8'hFF);
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (active[0]) cnt++;
    end
    chk("t2_no_second_frame", cnt, 0);
    chk("t3_flag_pre", int'(flag[0]), 1);
    clr_n[0] = 1'b0;
    @(negedge clk);
    clr_n[0] = 1'b1;
    chk("t3_clr_flag", int'(flag[0]), 0);
    chk("t3_clr_flag_n", int'(flag_n[0]), 1);
    d[0] = 8'($urandom);
    load_n[0] = 1'b0;
    @(negedge clk);
    load_n[0] = 1'b1;
    repeat (FL0_LIT - 1) @(negedge clk);
    clr_n[0] = 1'b0;
    @(negedge clk);
    clr_n[0] = 1'b1;
    chk("t3_set_wins", int'(flag[0]), 1);
    d[0] = 8'h80;
    load_n[0] = 1'b0;
    @(negedge clk);
    load_n[0] = 1'b1;
    repeat (59) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("t4_line", int'(line[0]), 1);
    chk("t4_active", int'(active[0]), 0);
    chk("t4_flag", int'(flag[0]), 0);
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (flag[0]) cnt++;
    end
    chk("t4_no_flag", cnt, 0);
    send(1, 8'h01, s, ftf);
    chk("t5_fall_to_flag", ftf, FL1_LIT);
    chk("t5_data", int'(s[8:1]), 8'h01);
    chk("t5_after_d7", int'(s[9]), 1);
    send(0, 8'h03, s, ftf);
    chk("t6_par03", int'(s[9]), PB == 1 ? 0 : 1);
    chk("t6_fall_to_flag", ftf, FL0_LIT);
    send(0, 8'h07, s, ftf);
    chk("t6_par07", int'(s[9]), 1);
    chk("t6_data07", int'(s[8:1]), 8'h07);
    repeat (4000) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        load_n[i] = $urandom_range(0, 9) != 0;
        clr_n[i] = $urandom_range(0, 19) != 0;
        rst[i] = $urandom_range(0, 999) == 0;
        d[i] = 8'($urandom);
      end
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/m707_tty_tx.md
Name: m707_tty_tx

Overview:
- Teletype transmitter. It is the send-side counterpart of the flip-flop based teletype receiver logic in the PDP-8/I model.
- Takes an 8-bit character from the AC bus on a negative-going load pulse and serialises it as an asynchronous start/data/stop frame on the 20 mA loop line.
- Raises a flag when the frame completes, for IOT skip/interrupt logic.
- Pulse inputs are edge-detected on the master clock, the same way the sn7473 flip-flops sample clk_n.

Parameters:
- BIT_CLKS, 16, master-clock cycles per serial bit; legal range is 2 or more.
- STOP_BITS, 2, number of stop (mark) bits; legal values are 1 or 2.

Ports:
- clk  input  1  master clock; every register is updated on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load_n  input  1  active-low load pulse; its falling edge starts a frame.
- clr_flag_n  input  1  active-low flag-clear pulse; its falling edge clears the flag.
- d  input  8  character to send, sampled on the load edge.
- line  output  1  serial output; 1 is mark/idle, 0 is space.
- flag  output  1  transmit-done flag.
- flag_n  output  1  complement of flag.
- active  output  1  high while a frame is in progress.

Behaviour:
- Edge detection:
  - Registers prev_load and prev_clr hold the previous samples; both reset to 1.
  - A load edge is prev_load=1 and load_n=0 in the same cycle. The clear edge is defined the same way.
  - A pulse held low produces exactly one edge.
- Reset values: line=1, flag=0, flag_n=1, active=0, state=IDLE, bit counter=0, divider=0, shift register=0.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: line=1. On a load edge, at the same clock edge: latch d into the shift register, clear flag, go to START, line=0, active=1, reset the divider.
  - START: line=0 for BIT_CLKS cycles, then go to DATA with line=d[0].
  - DATA: each bit lasts BIT_CLKS cycles. Bits go out LSB first, d[0] to d[7]. After d[7] completes, go to STOP with line=1.
  - STOP: line=1 for STOP_BITS*BIT_CLKS cycles. At the final cycle's edge: state=IDLE, active=0, flag=1.
- Timing:
  - line falls in the cycle after the edge that sampled the load edge.
  - The frame lasts (9+STOP_BITS)*BIT_CLKS cycles.
  - flag rises exactly (9+STOP_BITS)*BIT_CLKS cycles after line first falls.
- Load while not IDLE, including the cycle that sets flag: ignored. The frame in progress is not disturbed and flag is not affected.
- Flag clear edge coinciding with flag set: set wins, so flag=1.
- Flag clear edge coinciding with a load edge in IDLE: flag=0.
- rst mid-frame:
  - line returns to 1 on the next edge, active=0, and flag=0.
  - The partial frame is abandoned and no flag is raised.
- d changing after the load edge has no effect on the frame.

Optional Feature:
- Macro: M707_PARITY_EN.
- When defined: after d[7], one parity bit of BIT_CLKS cycles is sent before the stop bits.
  - The parity bit is even parity over d[7:0], i.e. the XOR of d.
  - Frame length becomes (10+STOP_BITS)*BIT_CLKS cycles; flag timing shifts accordingly.
  - The state machine gains a PARITY state between DATA and STOP.
- When undefined: there is no parity bit, no PARITY state, and no parity logic.

Test Plan:
1. BIT_CLKS=16, STOP_BITS=2, rst for 2 cycles, then load_n pulse low 1 cycle with d=0x55.
   -> line: 16 cycles of 0, then 1,0,1,0,1,0,1,0 at 16 cycles each, then 32 cycles of 1.
   -> active=1 throughout; flag rises exactly 176 cycles after line falls.
2. Load d=0xFF and hold load_n low for 40 cycles.
   -> exactly one frame is sent.
   -> a second load pulse at cycle 100 with d=0x00 is ignored; the line bit sequence still reflects 0xFF.
3. With flag set, apply a clr_flag_n pulse.
   -> flag=0 and flag_n=1 one edge later.
   -> a clear edge landing on the flag-set cycle of a following frame leaves flag=1.
4. Start a frame with d=0x80 and assert rst at cycle 60.
   -> line=1, active=0, flag=0 after the next edge.
   -> no flag appears over the following 200 cycles.
5. STOP_BITS=1, BIT_CLKS=4, d=0x01.
   -> frame is 40 cycles: line 0,1,0,0,0,0,0,0,0,1 at 4 cycles each; flag at cycle 40.
6. With M707_PARITY_EN defined, BIT_CLKS=16, STOP_BITS=2.
   -> d=0x03 gives parity bit 0; d=0x07 gives parity bit 1.
   -> flag rises 192 cycles after line falls.
